// File: rtl/ldm_stm_pkg.sv
// ldm_stm_pkg: shared types and helpers for the LDM/STM block-transfer sequencer.
//
// Contents:
//   state_t     - sequencer FSM state encoding
//   WORD_STEP   - address increment per transferred word
//   popcount16  - number of set bits in a 16-bit register list
//
// Build option used by the sequencer: LDM_STM_PC_LOAD_EN (see ldm_stm_sequencer.sv).
package ldm_stm_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_XFER = 3'd2,
    S_WB   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [31:0] WORD_STEP = 32'd4;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ldm_stm_sequencer_prio_enc16.sv
// prio_enc16: lowest-set-bit priority encoder over a 16-bit vector.
//
// Ports:
//   vec_i   in  16 : vector to scan
//   index_o out 4  : position of the lowest set bit (0 when vec_i is zero)
//   any_o   out 1  : at least one bit of vec_i is set
module prio_enc16 (
  input  logic [15:0] vec_i,
  output logic [3:0]  index_o,
  output logic        any_o
);

  always_comb begin
    index_o = 4'd0;
    any_o   = |vec_i;
    // Scan from the top down so the lowest set bit is the last one written.
    for (int i = 15; i >= 0; i--) begin
      if (vec_i[i]) index_o = 4'(i);
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: multi-cycle controller for ARM LDM/STM block transfers.
//
// Takes over regfile read port 2 (store data) and write port 3 while busy,
// walks the register list lowest-register-first at ascending addresses, and
// optionally writes the updated base back to Rn.
//
// Ports:
//   clk, reset_n                        clock, async active-low reset
//   start                               one-cycle request (ignored while busy)
//   is_load, pre_index, up, writeback   L/P/U/W bits, sampled with start
//   base_reg, reg_list, base_val        Rn, register list, value of Rn
//   rf_ra / rf_rd                       store-data read port
//   rf_we, rf_wa, rf_wd                 regfile write port
//   pc_we, pc_wd                        PC load request
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_ready, mem_rdata     data memory port
//   busy, done                          status
//   dbg_state                           current FSM state (observation only)
//
// Build option: LDM_STM_PC_LOAD_EN. When defined, list bit 15 is transferred
// and a load of R15 goes to pc_we/pc_wd. When undefined, bit 15 is dropped
// from the list and the PC port is tied off.
//
// Memory handshake: a beat is offered by holding mem_req=1 with mem_addr,
// mem_we and mem_wdata stable; it completes on the first rising edge where
// mem_req and mem_ready are both high (mem_ready may already be high in the
// first request cycle). Load data is taken from mem_rdata in that same cycle.
module ldm_stm_sequencer
  import ldm_stm_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        is_load,
  input  logic        pre_index,
  input  logic        up,
  input  logic        writeback,
  input  logic [3:0]  base_reg,
  input  logic [15:0] reg_list,
  input  logic [31:0] base_val,
  output logic [3:0]  rf_ra,
  input  logic [31:0] rf_rd,
  output logic        rf_we,
  output logic [3:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic        pc_we,
  output logic [31:0] pc_wd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output state_t      dbg_state
);

`ifdef LDM_STM_PC_LOAD_EN
  localparam logic [15:0] LIST_MASK = 16'hFFFF;
`else
  localparam logic [15:0] LIST_MASK = 16'h7FFF;
`endif

  state_t      state_q, state_d;
  logic [15:0] mask_q, mask_d;       // registers still to transfer
  logic [31:0] addr_q, addr_d;       // address of the current beat
  logic [31:0] base_q, base_d;
  logic [31:0] wb_val_q, wb_val_d;
  logic [3:0]  base_reg_q, base_reg_d;
  logic        is_load_q, is_load_d;
  logic        pre_q, pre_d;
  logic        up_q, up_d;
  logic        wb_req_q, wb_req_d;   // W bit as issued
  logic        do_wb_q, do_wb_d;     // W bit after the skip rules

  logic [3:0]  cur_idx;
  logic        cur_any;
  logic [4:0]  pop_n;
  logic [31:0] span;
  logic [15:0] mask_clr;

  prio_enc16 u_prio_enc16 (
    .vec_i   (mask_q),
    .index_o (cur_idx),
    .any_o   (cur_any)
  );

  assign pop_n = popcount16(mask_q);
  assign span  = 32'(pop_n) * WORD_STEP;

  always_comb begin
    mask_clr          = mask_q;
    mask_clr[cur_idx] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      mask_q     <= 16'd0;
      addr_q     <= 32'd0;
      base_q     <= 32'd0;
      wb_val_q   <= 32'd0;
      base_reg_q <= 4'd0;
      is_load_q  <= 1'b0;
      pre_q      <= 1'b0;
      up_q       <= 1'b0;
      wb_req_q   <= 1'b0;
      do_wb_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      addr_q     <= addr_d;
      base_q     <= base_d;
      wb_val_q   <= wb_val_d;
      base_reg_q <= base_reg_d;
      is_load_q  <= is_load_d;
      pre_q      <= pre_d;
      up_q       <= up_d;
      wb_req_q   <= wb_req_d;
      do_wb_q    <= do_wb_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    addr_d     = addr_q;
    base_d     = base_q;
    wb_val_d   = wb_val_q;
    base_reg_d = base_reg_q;
    is_load_d  = is_load_q;
    pre_d      = pre_q;
    up_d       = up_q;
    wb_req_d   = wb_req_q;
    do_wb_d    = do_wb_q;

    rf_ra      = 4'd0;
    rf_we      = 1'b0;
    rf_wa      = 4'd0;
    rf_wd      = 32'd0;
    pc_we      = 1'b0;
    pc_wd      = 32'd0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_load_d  = is_load;
          pre_d      = pre_index;
          up_d       = up;
          wb_req_d   = writeback;
          base_reg_d = base_reg;
          base_d     = base_val;
          mask_d     = reg_list & LIST_MASK;
          state_d    = S_CALC;
        end
      end

      S_CALC: begin
        // Transfers always run upward; descending modes just start lower.
        case ({pre_q, up_q})
          2'b01:   addr_d = base_q;
          2'b11:   addr_d = base_q + WORD_STEP;
          2'b00:   addr_d = base_q - span + WORD_STEP;
          default: addr_d = base_q - span;
        endcase
        wb_val_d = up_q ? (base_q + span) : (base_q - span);
        // A loaded base register keeps the loaded value, so no writeback then.
        do_wb_d  = wb_req_q && (base_reg_q != 4'd15) &&
                   !(is_load_q && mask_q[base_reg_q]);
        state_d  = (pop_n != 5'd0) ? S_XFER : S_DONE;
      end

      S_XFER: begin
        if (cur_any) begin
          mem_req  = 1'b1;
          mem_we   = !is_load_q;
          mem_addr = addr_q;
          if (!is_load_q) begin
            rf_ra     = cur_idx;
            mem_wdata = rf_rd;
          end
          if (mem_ready) begin
            mask_d = mask_clr;
            addr_d = addr_q + WORD_STEP;
            if (is_load_q) begin
`ifdef LDM_STM_PC_LOAD_EN
              if (cur_idx == 4'd15) begin
                pc_we = 1'b1;
                pc_wd = mem_rdata;
              end else begin
                rf_we = 1'b1;
                rf_wa = cur_idx;
                rf_wd = mem_rdata;
              end
`else
              rf_we = 1'b1;
              rf_wa = cur_idx;
              rf_wd = mem_rdata;
`endif
            end
            if (mask_clr == 16'd0) begin
              state_d = do_wb_q ? S_WB : S_DONE;
            end
          end
        end else begin
          state_d = S_DONE;
        end
      end

      S_WB: begin
        rf_we   = 1'b1;
        rf_wa   = base_reg_q;
        rf_wd   = wb_val_q;
        state_d = S_DONE;
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
module tb_ldm_stm_sequencer;
  import ldm_stm_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        is_load, pre_index, up, writeback;
  logic [3:0]  base_reg;
  logic [15:0] reg_list;
  logic [31:0] base_val;
  logic [3:0]  rf_ra;
  logic [31:0] rf_rd;
  logic        rf_we;
  logic [3:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        pc_we;
  logic [31:0] pc_wd;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy, done;
  state_t      dbg_state;

  int vec_count = 0;
  int err_count = 0;

  logic [31:0] rf [16];

  ldm_stm_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .is_load   (is_load),
    .pre_index (pre_index),
    .up        (up),
    .writeback (writeback),
    .base_reg  (base_reg),
    .reg_list  (reg_list),
    .base_val  (base_val),
    .rf_ra     (rf_ra),
    .rf_rd     (rf_rd),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .pc_we     (pc_we),
    .pc_wd     (pc_wd),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / environment ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file environment: rN resets to 0xA000000N.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) rf[i] <= 32'hA000_0000 | 32'(i);
    end else if (rf_we) begin
      rf[rf_wa] <= rf_wd;
    end
  end
  assign rf_rd = rf[rf_ra];

  // Memory returns 0xD0000000 | address for every read.
  assign mem_rdata = 32'hD000_0000 | mem_addr;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic l, input logic p, input logic u, input logic w,
                       input logic [3:0] rn, input logic [15:0] list, input logic [31:0] base);
    is_load = l; pre_index = p; up = u; writeback = w;
    base_reg = rn; reg_list = list; base_val = base;
    start = 1'b1;
    step();
    start = 1'b0;
    vec_count++;
    if (dbg_state !== S_CALC || busy !== 1'b1 || mem_req !== 1'b0) begin
      err_count++;
      $display("FAIL calc_entry: got state=%0d busy=%b req=%b, required state=1 busy=1 req=0",
               dbg_state, busy, mem_req);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    start = 0; is_load = 0; pre_index = 0; up = 0; writeback = 0;
    base_reg = 0; reg_list = 0; base_val = 0; mem_ready = 0;
    step(); step();
    vec_count++;
    if ({busy, done, mem_req, mem_we, rf_we, pc_we} !== 6'b0 || mem_addr !== 32'd0 ||
        mem_wdata !== 32'd0 || rf_wd !== 32'd0 || pc_wd !== 32'd0 || rf_ra !== 4'd0 ||
        dbg_state !== S_IDLE) begin
      err_count++;
      $display("FAIL reset_outputs: got busy=%b done=%b req=%b we=%b rf_we=%b pc_we=%b addr=%h state=%0d, required all 0",
               busy, done, mem_req, mem_we, rf_we, pc_we, mem_addr, dbg_state);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_ldmia();
    mem_ready = 1'b1;
    issue(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 16'h000E, 32'h100);
    for (int b = 0; b < 3; b++) begin
      step();
      vec_count++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 + 32'(4*b) ||
          rf_we !== 1'b1 || rf_wa !== 4'(b+1) || rf_wd !== 32'hD000_0100 + 32'(4*b) || done !== 1'b0) begin
        err_count++;
        $display("FAIL ldmia_beat%0d: got req=%b we=%b addr=%h rf_we=%b wa=%0d wd=%h, required 1 0 %h 1 %0d %h",
                 b, mem_req, mem_we, mem_addr, rf_we, rf_wa, rf_wd, 32'h100 + 32'(4*b), b+1, 32'hD000_0100 + 32'(4*b));
      end
    end
    step();
    vec_count++;
    if (dbg_state !== S_WB || rf_we !== 1'b1 || rf_wa !== 4'd0 || rf_wd !== 32'h10C ||
        mem_req !== 1'b0 || done !== 1'b0) begin
      err_count++;
      $display("FAIL ldmia_wb: got state=%0d rf_we=%b wa=%0d wd=%h req=%b, required 3 1 0 0000010c 0",
               dbg_state, rf_we, rf_wa, rf_wd, mem_req);
    end
    step();  // fifth edge after the start edge
    vec_count++;
    if (done !== 1'b1 || busy !== 1'b1 || rf_we !== 1'b0) begin
      err_count++;
      $display("FAIL ldmia_done: got done=%b busy=%b rf_we=%b, required 1 1 0", done, busy, rf_we);
    end
    step();
    vec_count++;
    if (done !== 1'b0 || busy !== 1'b0 || rf[0] !== 32'h10C || rf[1] !== 32'hD000_0100 ||
        rf[2] !== 32'hD000_0104 || rf[3] !== 32'hD000_0108) begin
      err_count++;
      $display("FAIL ldmia_regs: got done=%b busy=%b r0=%h r1=%h r2=%h r3=%h, required 0 0 0000010c d0000100 d0000104 d0000108",
               done, busy, rf[0], rf[1], rf[2], rf[3]);
    end
  endtask

  task automatic test_stmdb();
    mem_ready = 1'b1;
    issue(1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 16'h4010, 32'h2000);
    step();
    vec_count++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h1FF8 || rf_ra !== 4'd4 ||
        mem_wdata !== 32'hA000_0004 || rf_we !== 1'b0 || pc_we !== 1'b0) begin
      err_count++;
      $display("FAIL stmdb_beat0: got req=%b we=%b addr=%h ra=%0d wdata=%h rf_we=%b, required 1 1 00001ff8 4 a0000004 0",
               mem_req, mem_we, mem_addr, rf_ra, mem_wdata, rf_we);
    end
    // A start pulse while busy must be ignored.
    start = 1'b1; is_load = 1'b1; reg_list = 16'hFFFF; base_val = 32'h0;
    step();
    start = 1'b0;
    vec_count++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h1FFC || rf_ra !== 4'd14 ||
        mem_wdata !== 32'hA000_000E || rf_we !== 1'b0) begin
      err_count++;
      $display("FAIL stmdb_beat1: got req=%b we=%b addr=%h ra=%0d wdata=%h rf_we=%b, required 1 1 00001ffc 14 a000000e 0",
               mem_req, mem_we, mem_addr, rf_ra, mem_wdata, rf_we);
    end
    step();
    vec_count++;
    if (rf_we !== 1'b1 || rf_wa !== 4'd13 || rf_wd !== 32'h1FF8 || mem_req !== 1'b0) begin
      err_count++;
      $display("FAIL stmdb_wb: got rf_we=%b wa=%0d wd=%h req=%b, required 1 13 00001ff8 0",
               rf_we, rf_wa, rf_wd, mem_req);
    end
    step();
    vec_count++;
    if (done !== 1'b1) begin
      err_count++;
      $display("FAIL stmdb_done: got done=%b, required 1", done);
    end
    step();
    vec_count++;
    if (busy !== 1'b0 || rf[13] !== 32'h1FF8 || rf[4] !== 32'hA000_0004) begin
      err_count++;
      $display("FAIL stmdb_regs: got busy=%b r13=%h r4=%h, required 0 00001ff8 a0000004", busy, rf[13], rf[4]);
    end
  endtask

  task automatic test_ldmib_wait();
    mem_ready = 1'b0;
    issue(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 16'h0003, 32'h300);
    for (int w = 0; w < 3; w++) begin
      step();
      vec_count++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h304 || rf_we !== 1'b0) begin
        err_count++;
        $display("FAIL ldmib_wait%0d: got req=%b we=%b addr=%h rf_we=%b, required 1 0 00000304 0",
                 w, mem_req, mem_we, mem_addr, rf_we);
      end
    end
    mem_ready = 1'b1;
    #1;
    vec_count++;
    if (rf_we !== 1'b1 || rf_wa !== 4'd0 || rf_wd !== 32'hD000_0304 || mem_addr !== 32'h304) begin
      err_count++;
      $display("FAIL ldmib_ready: got rf_we=%b wa=%0d wd=%h addr=%h, required 1 0 d0000304 00000304",
               rf_we, rf_wa, rf_wd, mem_addr);
    end
    step();
    vec_count++;
    if (mem_addr !== 32'h308 || rf_wa !== 4'd1 || rf_wd !== 32'hD000_0308 || rf_we !== 1'b1) begin
      err_count++;
      $display("FAIL ldmib_beat1: got addr=%h wa=%0d wd=%h rf_we=%b, required 00000308 1 d0000308 1",
               mem_addr, rf_wa, rf_wd, rf_we);
    end
    step();  // W=0: straight to DONE
    vec_count++;
    if (done !== 1'b1 || rf_we !== 1'b0 || rf[5] !== 32'hA000_0005) begin
      err_count++;
      $display("FAIL ldmib_done: got done=%b rf_we=%b r5=%h, required 1 0 a0000005", done, rf_we, rf[5]);
    end
    step();
  endtask

  task automatic test_ldm_base_in_list();
    mem_ready = 1'b1;
    issue(1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 16'h0006, 32'h500);
    step();
    step();
    vec_count++;
    if (rf_wa !== 4'd2 || rf_wd !== 32'hD000_0504 || mem_addr !== 32'h504) begin
      err_count++;
      $display("FAIL ldm_base_beat1: got wa=%0d wd=%h addr=%h, required 2 d0000504 00000504", rf_wa, rf_wd, mem_addr);
    end
    step();  // no WB: DONE three edges after the start edge
    vec_count++;
    if (done !== 1'b1 || rf_we !== 1'b0) begin
      err_count++;
      $display("FAIL ldm_base_done: got done=%b rf_we=%b, required 1 0", done, rf_we);
    end
    step();
    vec_count++;
    if (rf[2] !== 32'hD000_0504 || rf[1] !== 32'hD000_0500) begin
      err_count++;
      $display("FAIL ldm_base_regs: got r1=%h r2=%h, required d0000500 d0000504", rf[1], rf[2]);
    end
  endtask

  task automatic test_pc_load();
    mem_ready = 1'b1;
    issue(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 16'h8001, 32'h40);
`ifdef LDM_STM_PC_LOAD_EN
    step();
    vec_count++;
    if (mem_addr !== 32'h3C || rf_we !== 1'b1 || rf_wa !== 4'd0 || rf_wd !== 32'hD000_003C || pc_we !== 1'b0) begin
      err_count++;
      $display("FAIL pc_beat0: got addr=%h rf_we=%b wa=%0d wd=%h pc_we=%b, required 0000003c 1 0 d000003c 0",
               mem_addr, rf_we, rf_wa, rf_wd, pc_we);
    end
    step();
    vec_count++;
    if (mem_addr !== 32'h40 || rf_we !== 1'b0 || pc_we !== 1'b1 || pc_wd !== 32'hD000_0040) begin
      err_count++;
      $display("FAIL pc_beat1: got addr=%h rf_we=%b pc_we=%b pc_wd=%h, required 00000040 0 1 d0000040",
               mem_addr, rf_we, pc_we, pc_wd);
    end
`else
    step();
    vec_count++;
    if (mem_addr !== 32'h40 || rf_we !== 1'b1 || rf_wa !== 4'd0 || rf_wd !== 32'hD000_0040 || pc_we !== 1'b0) begin
      err_count++;
      $display("FAIL pc_masked_beat0: got addr=%h rf_we=%b wa=%0d wd=%h pc_we=%b, required 00000040 1 0 d0000040 0",
               mem_addr, rf_we, rf_wa, rf_wd, pc_we);
    end
`endif
    step();
    vec_count++;
    if (done !== 1'b1 || mem_req !== 1'b0 || pc_we !== 1'b0) begin
      err_count++;
      $display("FAIL pc_done: got done=%b req=%b pc_we=%b, required 1 0 0", done, mem_req, pc_we);
    end
    step();
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b1;
    issue(1'b1, 1'b0, 1'b1, 1'b1, 4'd8, 16'h00F0, 32'h600);
    step();
    step();  // second beat in progress
    reset_n = 1'b0;
    #1;
    vec_count++;
    if ({busy, done, mem_req, mem_we, rf_we, pc_we} !== 6'b0 || mem_addr !== 32'd0 ||
        rf_wd !== 32'd0 || dbg_state !== S_IDLE) begin
      err_count++;
      $display("FAIL reset_mid: got busy=%b done=%b req=%b rf_we=%b addr=%h state=%0d, required all 0",
               busy, done, mem_req, rf_we, mem_addr, dbg_state);
    end
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      vec_count++;
      if (rf_we !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) begin
        err_count++;
        $display("FAIL reset_mid_after%0d: got rf_we=%b req=%b busy=%b, required 0 0 0", c, rf_we, mem_req, busy);
      end
    end
  endtask

  task automatic test_empty();
    mem_ready = 1'b1;
    issue(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 16'h0000, 32'h100);
    step();
    vec_count++;
    if (done !== 1'b1 || mem_req !== 1'b0 || rf_we !== 1'b0) begin
      err_count++;
      $display("FAIL empty_done: got done=%b req=%b rf_we=%b, required 1 0 0", done, mem_req, rf_we);
    end
    step();
    vec_count++;
    if (busy !== 1'b0 || done !== 1'b0 || rf[0] !== 32'hA000_0000) begin
      err_count++;
      $display("FAIL empty_idle: got busy=%b done=%b r0=%h, required 0 0 a0000000", busy, done, rf[0]);
    end
  endtask

  initial begin
    test_reset();
    test_ldmia();
    test_stmdb();
    test_ldmib_wait();
    test_ldm_base_in_list();
    test_pc_load();
    test_reset_mid();
    test_empty();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
